imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 30 +++
 rtl/imem_boot_loader_if.sv | 31 +++
 rtl/imem_boot_loader_word_packer.sv | 55 +++++
 rtl/imem_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared types and parameter helpers for the instruction-memory boot loader.
//   loader_state_t : IDLE / LOAD / DRAIN / RUN
//   calc_beats     : input beats per instruction word
//   calc_max_words : instruction words that fit in the memory
//   width_ok       : true when the beat width divides the word width
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

    function automatic int unsigned calc_beats(int unsigned data_width, int unsigned in_width);
        return data_width / in_width;
    endfunction

    function automatic int unsigned calc_max_words(int unsigned mem_depth, int unsigned data_width);
        return (mem_depth * 8) / data_width;
    endfunction

    function automatic bit width_ok(int unsigned data_width, int unsigned in_width);
        return (in_width != 0) && (in_width <= data_width) && ((data_width % in_width) == 0);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the input beat stream and the instruction-memory write port.
//   s_valid / s_data / s_ready            : beat stream (source -> loader)
//   imem_w_en / imem_wr_addr / imem_data_in : memory write port (loader -> memory)
// Modports:
//   slave  : the loader side (consumes beats, drives the write port)
//   master : the environment side (produces beats, observes the write port)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  s_valid;
    logic [IN_WIDTH-1:0]   s_data;
    logic                  s_ready;
    logic                  imem_w_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [DATA_WIDTH-1:0] imem_data_in;

    modport slave (
        input  s_valid, s_data,
        output s_ready, imem_w_en, imem_wr_addr, imem_data_in
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, imem_w_en, imem_wr_addr, imem_data_in
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_word_packer
// Assembles IN_WIDTH beats into a DATA_WIDTH word, little-endian (first beat
// lands in the lowest lane).
//   clk, arst_n : clock, asynchronous active-low reset
//   clear       : discard any partial word and restart at lane 0
//   accept      : a beat is being consumed this cycle
//   beat        : the beat data
//   word        : the word including the beat currently being accepted
//   word_done   : high in the cycle the last lane of a word is accepted
// ---------------------------------------------------------------------------
module imem_boot_loader_word_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned BEATS      = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [IN_WIDTH-1:0]   beat,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_done
);

    // Keep the counter at least one bit wide so BEATS == 1 still elaborates.
    localparam int unsigned    CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]      beat_cnt;
    logic [DATA_WIDTH-1:0] word_q;

    assign word_done = accept && (beat_cnt == LAST);

    // Merge the incoming beat into its lane so the completed word is
    // available in the same cycle the final beat is accepted.
    always_comb begin
        word = word_q;
        word[beat_cnt * IN_WIDTH +: IN_WIDTH] = beat;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            beat_cnt <= '0;
            word_q   <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            word_q   <= '0;
        end else if (accept) begin
            word_q   <= word;
            beat_cnt <= word_done ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Program-load engine between a narrow beat stream and the instruction-memory
// write port. Packs beats into words, writes them to consecutive addresses
// from BASE_ADDR, then holds the core released with prog_ack.
//   clk, arst_n  : clock, asynchronous active-low reset
//   prog_ready   : level; rising edge starts a load, low returns to idle
//   prog_len     : program length in words, sampled on the prog_ready rise
//   bus          : beat stream in, memory write port out (slave modport)
//   prog_ack     : program loaded, core may run
//   busy         : loading or draining
//   error        : sticky, requested length exceeds memory capacity
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  prog_ready,
    input  logic [ADDR_WIDTH:0]   prog_len,
    imem_boot_loader_if.slave     bus,
    output logic                  prog_ack,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned BEATS     = calc_beats(DATA_WIDTH, IN_WIDTH);
    localparam int unsigned MAX_WORDS = calc_max_words(MEM_DEPTH, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    if (!width_ok(DATA_WIDTH, IN_WIDTH)) begin : g_width_check
        $error("imem_boot_loader: IN_WIDTH must divide DATA_WIDTH");
    end

    loader_state_t         state;
    logic                  prog_ready_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  s_ready_q;
    logic                  w_en_q;

    logic                  ready_rise;
    logic                  beat_accept;
    logic                  packer_clear;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] packed_word;

    assign ready_rise   = prog_ready & ~prog_ready_q;
    // A beat arriving in the same cycle as an abort is dropped with the
    // rest of the partial word, so it is not counted.
    assign beat_accept  = bus.s_valid & s_ready_q & prog_ready;
    assign packer_clear = (state != LOAD);

    imem_boot_loader_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_WIDTH   (IN_WIDTH),
        .BEATS      (BEATS)
    ) u_packer (
        .clk        (clk),
        .arst_n     (arst_n),
        .clear      (packer_clear),
        .accept     (beat_accept),
        .beat       (bus.s_data),
        .word       (packed_word),
        .word_done  (word_done)
    );

    // Control FSM with registered outputs. The write address is captured
    // into its own register so the running address can advance while the
    // previous word is still on the write port (needed when BEATS == 1).
    // prog_ack is set from DRAIN or from RUN so it is always a full cycle
    // behind entry into the run phase.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            prog_ready_q <= 1'b0;
            len_q        <= '0;
            word_cnt     <= '0;
            addr         <= BASE;
            wr_addr_q    <= BASE;
            data_q       <= '0;
            s_ready_q    <= 1'b0;
            w_en_q       <= 1'b0;
            prog_ack     <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            prog_ready_q <= prog_ready;
            w_en_q       <= 1'b0;
            unique case (state)
                IDLE: begin
                    s_ready_q <= 1'b0;
                    busy      <= 1'b0;
                    prog_ack  <= 1'b0;
                    if (ready_rise) begin
                        if (32'(prog_len) > MAX_WORDS) begin
                            error <= 1'b1;
                        end else if (prog_len == '0) begin
                            error <= 1'b0;
                            state <= RUN;
                        end else begin
                            error     <= 1'b0;
                            len_q     <= prog_len;
                            word_cnt  <= '0;
                            addr      <= BASE;
                            s_ready_q <= 1'b1;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (!prog_ready) begin
                        s_ready_q <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (word_done) begin
                        w_en_q    <= 1'b1;
                        data_q    <= packed_word;
                        wr_addr_q <= addr;
                        addr      <= addr + STEP;
                        word_cnt  <= word_cnt + 1'b1;
                        if (word_cnt == len_q - 1'b1) begin
                            s_ready_q <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    busy <= 1'b0;
                    if (!prog_ready) begin
                        state <= IDLE;
                    end else begin
                        prog_ack <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!prog_ready) begin
                        prog_ack <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        prog_ack <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.imem_w_en    = w_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_data_in = data_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed bench for the boot loader: a byte-wide instance (defaults) and a
// word-wide instance (IN_WIDTH = 32). Inputs change on the falling edge and
// outputs are read on the falling edge, so each read reflects the preceding
// rising edge.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    logic        prog_ready8  = 1'b0;
    logic [10:0] prog_len8    = '0;
    logic        prog_ack8, busy8, error8;
    logic        prog_ready32 = 1'b0;
    logic [10:0] prog_len32   = '0;
    logic        prog_ack32, busy32, error32;

    int checks = 0;
    int errors = 0;

    imem_boot_loader_if #(.DATA_WIDTH(32), .IN_WIDTH(8),  .ADDR_WIDTH(10)) if8 ();
    imem_boot_loader_if #(.DATA_WIDTH(32), .IN_WIDTH(32), .ADDR_WIDTH(10)) if32 ();

    imem_boot_loader #(
        .DATA_WIDTH(32), .IN_WIDTH(8), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .BASE_ADDR(0)
    ) u_dut8 (
        .clk(clk), .arst_n(arst_n), .prog_ready(prog_ready8), .prog_len(prog_len8),
        .bus(if8), .prog_ack(prog_ack8), .busy(busy8), .error(error8)
    );

    imem_boot_loader #(
        .DATA_WIDTH(32), .IN_WIDTH(32), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .BASE_ADDR(0)
    ) u_dut32 (
        .clk(clk), .arst_n(arst_n), .prog_ready(prog_ready32), .prog_len(prog_len32),
        .bus(if32), .prog_ack(prog_ack32), .busy(busy32), .error(error32)
    );

    // Write log of every memory write seen on each instance.
    logic [9:0]  wa8[$];
    logic [31:0] wd8[$];
    logic [9:0]  wa32[$];
    logic [31:0] wd32[$];

    always @(negedge clk) begin
        if (if8.imem_w_en === 1'b1) begin
            wa8.push_back(if8.imem_wr_addr);
            wd8.push_back(if8.imem_data_in);
        end
        if (if32.imem_w_en === 1'b1) begin
            wa32.push_back(if32.imem_wr_addr);
            wd32.push_back(if32.imem_data_in);
        end
    end

    task automatic test_reset();
        #1 arst_n = 1'b0;
        #1;
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", if8.s_ready); end
        checks++; if (if8.imem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_en: got %b expected 0", if8.imem_w_en); end
        checks++; if (if8.imem_wr_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000", if8.imem_wr_addr); end
        checks++; if (if8.imem_data_in !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", if8.imem_data_in); end
        checks++; if (prog_ack8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", prog_ack8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
        checks++; if (error8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", error8); end
        checks++; if (if32.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready32: got %b expected 0", if32.s_ready); end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [7:0] beats [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wa8.delete(); wd8.delete();
        @(negedge clk);
        prog_len8 = 11'd2; prog_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (if8.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_s_ready[%0d]: got %b expected 1", i, if8.s_ready); end
            checks++; if (if8.imem_w_en !== 1'(i == 4)) begin errors++; $display("[TB] FAIL basic_w_en[%0d]: got %b expected %b", i, if8.imem_w_en, (i == 4)); end
            if (i == 4) begin
                checks++; if (if8.imem_data_in !== 32'h00000013) begin errors++; $display("[TB] FAIL basic_word0: got %h expected 00000013", if8.imem_data_in); end
                checks++; if (if8.imem_wr_addr !== 10'h000) begin errors++; $display("[TB] FAIL basic_addr0: got %h expected 000", if8.imem_wr_addr); end
            end
            if8.s_valid = 1'b1; if8.s_data = beats[i];
        end
        @(negedge clk);
        if8.s_valid = 1'b0;
        checks++; if (if8.imem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL basic_w_en_last: got %b expected 1", if8.imem_w_en); end
        checks++; if (if8.imem_data_in !== 32'h00100093) begin errors++; $display("[TB] FAIL basic_word1: got %h expected 00100093", if8.imem_data_in); end
        checks++; if (if8.imem_wr_addr !== 10'h004) begin errors++; $display("[TB] FAIL basic_addr1: got %h expected 004", if8.imem_wr_addr); end
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain_s_ready: got %b expected 0", if8.s_ready); end
        checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL basic_drain_busy: got %b expected 1", busy8); end
        checks++; if (prog_ack8 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_early: got %b expected 0", prog_ack8); end
        @(negedge clk);
        checks++; if (prog_ack8 !== 1'b1) begin errors++; $display("[TB] FAIL basic_ack: got %b expected 1", prog_ack8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL basic_run_busy: got %b expected 0", busy8); end
        #1;
        checks++; if (wa8.size() !== 2) begin errors++; $display("[TB] FAIL basic_write_count: got %0d expected 2", wa8.size()); end
        prog_ready8 = 1'b0;
        @(negedge clk);
        checks++; if (prog_ack8 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_release: got %b expected 0", prog_ack8); end
    endtask

    task automatic test_wide_beats();
        logic [31:0] words [3] = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
        logic [9:0]  addrs [3] = '{10'h000, 10'h004, 10'h008};
        bit          pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        wa32.delete(); wd32.delete();
        @(negedge clk);
        prog_len32 = 11'd3; prog_ready32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (if32.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL wide_s_ready: got %b expected 1", if32.s_ready); end
            end else begin
                checks++; if (if32.imem_w_en !== 1'(pattern[i-1])) begin errors++; $display("[TB] FAIL wide_w_en[%0d]: got %b expected %b", i, if32.imem_w_en, pattern[i-1]); end
            end
            if32.s_valid = pattern[i];
            if (pattern[i]) begin
                if32.s_data = words[k];
                k++;
            end else begin
                if32.s_data = 32'hFFFF_FFFF;
            end
        end
        @(negedge clk);
        if32.s_valid = 1'b0;
        checks++; if (if32.imem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL wide_w_en_last: got %b expected 1", if32.imem_w_en); end
        checks++; if (if32.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL wide_drain_s_ready: got %b expected 0", if32.s_ready); end
        @(negedge clk);
        checks++; if (prog_ack32 !== 1'b1) begin errors++; $display("[TB] FAIL wide_ack: got %b expected 1", prog_ack32); end
        #1;
        checks++; if (wa32.size() !== 3) begin errors++; $display("[TB] FAIL wide_write_count: got %0d expected 3", wa32.size()); end
        if (wa32.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                checks++; if (wa32[j] !== addrs[j]) begin errors++; $display("[TB] FAIL wide_addr[%0d]: got %h expected %h", j, wa32[j], addrs[j]); end
                checks++; if (wd32[j] !== words[j]) begin errors++; $display("[TB] FAIL wide_data[%0d]: got %h expected %h", j, wd32[j], words[j]); end
            end
        end
        prog_ready32 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] beats [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        wa8.delete(); wd8.delete();
        @(negedge clk);
        prog_len8 = 11'd257; prog_ready8 = 1'b1;
        @(negedge clk);
        checks++; if (error8 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_error: got %b expected 1", error8); end
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_s_ready: got %b expected 0", if8.s_ready); end
        repeat (3) @(negedge clk);
        checks++; if (error8 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_error_sticky: got %b expected 1", error8); end
        checks++; if (prog_ack8 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ack: got %b expected 0", prog_ack8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_busy: got %b expected 0", busy8); end
        #1;
        checks++; if (wa8.size() !== 0) begin errors++; $display("[TB] FAIL ovf_no_write: got %0d writes expected 0", wa8.size()); end
        prog_ready8 = 1'b0;
        @(negedge clk);
        prog_len8 = 11'd1; prog_ready8 = 1'b1;
        @(negedge clk);
        checks++; if (error8 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_error_clear: got %b expected 0", error8); end
        checks++; if (if8.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_reload_s_ready: got %b expected 1", if8.s_ready); end
        if8.s_valid = 1'b1; if8.s_data = beats[0];
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if8.s_data = beats[i];
        end
        @(negedge clk);
        if8.s_valid = 1'b0;
        checks++; if (if8.imem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL ovf_reload_w_en: got %b expected 1", if8.imem_w_en); end
        checks++; if (if8.imem_data_in !== 32'h12345678) begin errors++; $display("[TB] FAIL ovf_reload_data: got %h expected 12345678", if8.imem_data_in); end
        @(negedge clk);
        checks++; if (prog_ack8 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_reload_ack: got %b expected 1", prog_ack8); end
        prog_ready8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [7:0] beats [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] again [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wa8.delete(); wd8.delete();
        @(negedge clk);
        prog_len8 = 11'd2; prog_ready8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if8.s_valid = 1'b1; if8.s_data = beats[i];
        end
        @(negedge clk);
        prog_ready8 = 1'b0; if8.s_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy8); end
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_s_ready: got %b expected 0", if8.s_ready); end
        repeat (3) @(negedge clk);
        checks++; if (prog_ack8 !== 1'b0) begin errors++; $display("[TB] FAIL abort_ack: got %b expected 0", prog_ack8); end
        #1;
        checks++; if (wa8.size() !== 1) begin errors++; $display("[TB] FAIL abort_write_count: got %0d expected 1", wa8.size()); end
        if (wa8.size() == 1) begin
            checks++; if (wd8[0] !== 32'h44332211) begin errors++; $display("[TB] FAIL abort_word0: got %h expected 44332211", wd8[0]); end
        end
        prog_len8 = 11'd1; prog_ready8 = 1'b1;
        @(negedge clk);
        checks++; if (if8.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload_s_ready: got %b expected 1", if8.s_ready); end
        if8.s_valid = 1'b1; if8.s_data = again[0];
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if8.s_data = again[i];
        end
        @(negedge clk);
        if8.s_valid = 1'b0;
        checks++; if (if8.imem_data_in !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL abort_reload_data: got %h expected deadbeef", if8.imem_data_in); end
        checks++; if (if8.imem_wr_addr !== 10'h000) begin errors++; $display("[TB] FAIL abort_reload_addr: got %h expected 000", if8.imem_wr_addr); end
        @(negedge clk);
        checks++; if (prog_ack8 !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload_ack: got %b expected 1", prog_ack8); end
        prog_ready8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        prog_len8 = 11'd0; prog_ready8 = 1'b1;
        @(negedge clk);
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_s_ready: got %b expected 0", if8.s_ready); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 0", busy8); end
        @(negedge clk);
        checks++; if (prog_ack8 !== 1'b1) begin errors++; $display("[TB] FAIL zero_ack: got %b expected 1", prog_ack8); end
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_s_ready_run: got %b expected 0", if8.s_ready); end
        prog_ready8 = 1'b0;
        @(negedge clk);
        checks++; if (prog_ack8 !== 1'b0) begin errors++; $display("[TB] FAIL zero_ack_release: got %b expected 0", prog_ack8); end
    endtask

    task automatic test_async_reset();
        logic [7:0] beats [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        logic [7:0] again [4]  = '{8'h0D, 8'hF0, 8'hAD, 8'h8B};
        @(negedge clk);
        prog_len8 = 11'd3; prog_ready8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if8.s_valid = 1'b1; if8.s_data = beats[i];
        end
        @(negedge clk);
        if8.s_valid = 1'b0;
        checks++; if (if8.imem_wr_addr !== 10'h004) begin errors++; $display("[TB] FAIL arst_pre_addr: got %h expected 004", if8.imem_wr_addr); end
        checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_busy: got %b expected 1", busy8); end
        #2 arst_n = 1'b0;
        #1;
        checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL arst_s_ready: got %b expected 0", if8.s_ready); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b expected 0", busy8); end
        checks++; if (if8.imem_wr_addr !== 10'h000) begin errors++; $display("[TB] FAIL arst_addr: got %h expected 000", if8.imem_wr_addr); end
        checks++; if (if8.imem_data_in !== 32'h0) begin errors++; $display("[TB] FAIL arst_data: got %h expected 00000000", if8.imem_data_in); end
        prog_ready8 = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        prog_len8 = 11'd1; prog_ready8 = 1'b1;
        @(negedge clk);
        if8.s_valid = 1'b1; if8.s_data = again[0];
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if8.s_data = again[i];
        end
        @(negedge clk);
        if8.s_valid = 1'b0;
        checks++; if (if8.imem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL arst_reload_w_en: got %b expected 1", if8.imem_w_en); end
        checks++; if (if8.imem_data_in !== 32'h8BADF00D) begin errors++; $display("[TB] FAIL arst_reload_data: got %h expected 8badf00d", if8.imem_data_in); end
        checks++; if (if8.imem_wr_addr !== 10'h000) begin errors++; $display("[TB] FAIL arst_reload_addr: got %h expected 000", if8.imem_wr_addr); end
        prog_ready8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        if8.s_valid  = 1'b0; if8.s_data  = '0;
        if32.s_valid = 1'b0; if32.s_data = '0;
        test_reset();
        test_basic_load();
        test_wide_beats();
        test_overflow();
        test_abort();
        test_zero_len();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
